keycode_event_queue: RTL
========================

Name: keycode_event_queue

Overview:
- Consumes the 16-bit keycode bus driven by the NIOS-written keycode PIO: two 8-bit USB HID usage codes, slot0 = bits [7:0], slot1 = bits [15:8].
- Converts level snapshots into discrete press/release events and queues them in a small FIFO.
- Game/FSM logic drains the FIFO through a valid/ready handshake.
- Also exports a held-key bitmask for the fixed set of game keys.

Parameters:
- FIFO_DEPTH, 8, event FIFO entries; power of two, minimum 2.
- REPEAT_DELAY, 25000000, cycles from press to first auto-repeat (used only with the optional feature).
- REPEAT_PERIOD, 5000000, cycles between auto-repeats (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- keycode  in  16  keycode PIO out_port
- evt_valid  out  1  FIFO non-empty
- evt_ready  in  1  consumer pop request; pop occurs when evt_valid & evt_ready
- evt_code  out  8  head event usage code; 0 when empty
- evt_press  out  1  head event type: 1 = press, 0 = release; 0 when empty
- evt_repeat  out  1  head event is an auto-repeat; 0 when empty
- held_mask  out  8  held game keys. Bits 0..7 = W 0x1A, A 0x04, S 0x16, D 0x07, Space 0x2C, Enter 0x28, Up 0x52, Down 0x51
- fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy
- overflow  out  1  sticky: an event was dropped
- clear_ovf  in  1  clears overflow

Behaviour:
- Reset (synchronous, active-high) clears:
  - registers kc_q, prev, snap (all to 0x0000) and the FIFO pointers;
  - outputs fifo_count, overflow, held_mask to 0; evt_valid to 0;
  - state to IDLE.
- kc_q <= keycode every cycle. This is the only sampling point.
- Normalisation, applied when a snapshot is taken:
  - If slot1 == slot0, slot1 is treated as 0x00.
  - If either slot is in 0x01..0x03 (HID error codes), the snapshot is rejected: no events, prev unchanged, stay in IDLE.
- FSM states: IDLE, REL0, REL1, PRS0, PRS1, COMMIT.
  - IDLE: if normalised kc_q != prev, then snap <= normalised kc_q and go to REL0.
  - REL0: push release(prev.slot0) if prev.slot0 != 0 and is not present in snap; go to REL1.
  - REL1: same test for prev.slot1; go to PRS0.
  - PRS0: push press(snap.slot0) if snap.slot0 != 0 and is not present in prev; go to PRS1.
  - PRS1: same test for snap.slot1; go to COMMIT.
  - COMMIT: prev <= snap; held_mask recomputed from snap; go to IDLE.
- Ordering and latency:
  - At most one push per cycle. Releases always precede presses; slot0 precedes slot1.
  - Keycode change before edge N: kc_q at N, REL0 from N+1, release pushed at N+2, press slot0 pushed at N+4, held_mask updated at N+6.
  - A full scan is fixed at 6 cycles.
- Keycode changes during a scan are not lost: snap is frozen, and the next IDLE compares kc_q against the updated prev.
- FIFO: a registered memory with a combinational head. A push when full is dropped and sets overflow, unless a pop occurs in the same cycle; in that case the push is accepted and fifo_count is unchanged. A pop when empty has no effect.
- Overflow is cleared by clear_ovf. If set and clear occur in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH.
- Reset mid-scan discards snap and any pending events. No partial commit.

Optional Feature:
- Macro: KEYCODE_AUTOREPEAT_EN.
- Defined:
  - A repeat counter tracks prev.slot0 while it is non-zero.
  - The counter resets on every COMMIT.
  - After REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles, the block pushes press(prev.slot0) with evt_repeat = 1.
  - Repeat pushes are issued only in IDLE. If the FIFO is full, the repeat is skipped and does not set overflow.
- Not defined: no counter logic; evt_repeat is tied to 0.

Test Plan:
- Reset, then hold keycode 0x0000 → evt_valid = 0, fifo_count = 0, held_mask = 0x00, overflow = 0.
- keycode 0x0000 → 0x001A → single press event code 0x1A, press = 1, first visible 4 cycles after kc_q update; held_mask = 0x01.
- keycode 0x071A → 0x0400 → events in order: release 0x1A, release 0x07, press 0x04; held_mask = 0x02.
- keycode 0x0101 (rollover error), then 0x0000 → no events; prev and held_mask unchanged.
- evt_ready = 0; toggle keycode between 0x002C and 0x0000 for 5 transitions (5 events, FIFO_DEPTH = 4) → fifo_count = 4 and overflow = 1; the four queued events drain in order; overflow stays 1 until clear_ovf pulses.
- With KEYCODE_AUTOREPEAT_EN, REPEAT_DELAY = 10, REPEAT_PERIOD = 4, hold 0x0052 → press 0x52 (repeat = 0), then repeat presses 10 cycles after COMMIT and every 4 cycles thereafter; the release of 0x52 stops repeats.

Source files
------------

// File: rtl/keycode_event_queue.sv
// Converts keycode PIO level snapshots into a queue of press/release events.
// Optional auto-repeat of the held slot0 key: define KEYCODE_AUTOREPEAT_EN.
module keycode_event_queue #(
  parameter int FIFO_DEPTH    = 8,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   keycode,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [7:0]                    evt_code,
  output logic                          evt_press,
  output logic                          evt_repeat,
  output logic [7:0]                    held_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clear_ovf
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef KEYCODE_AUTOREPEAT_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif

  // Bit i of held_mask tracks GAME_KEYS[i].
  localparam logic [7:0][7:0] GAME_KEYS = {8'h51, 8'h52, 8'h28, 8'h2C,
                                           8'h07, 8'h16, 8'h04, 8'h1A};

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_param
    $error("keycode_event_queue: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, REL0, REL1, PRS0, PRS1, COMMIT} state_t;

  function automatic logic is_err(input logic [7:0] c);
    return (c >= 8'h01) && (c <= 8'h03);
  endfunction

  function automatic logic in_set(input logic [7:0] c, input logic [15:0] s);
    return (c == s[7:0]) || (c == s[15:8]);
  endfunction

  function automatic logic [7:0] key_mask(input logic [15:0] s);
    logic [7:0] m;
    m = 8'h00;
    for (int i = 0; i < 8; i++)
      if (in_set(GAME_KEYS[i], s)) m[i] = 1'b1;
    return m;
  endfunction

  state_t          state, state_nx;
  logic [15:0]     kc_q, prev, snap, kc_norm;
  logic            kc_err;
  logic            scan_push, scan_press;
  logic [7:0]      scan_code;
  logic            push, pop, full, empty, wr_en, drop;
  logic [EW-1:0]   push_entry, head;
  logic [EW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  always_comb begin
    kc_norm = kc_q;
    if (kc_q[15:8] == kc_q[7:0]) kc_norm[15:8] = 8'h00;
    kc_err = is_err(kc_q[7:0]) || is_err(kc_q[15:8]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      kc_q      <= 16'h0000;
      prev      <= 16'h0000;
      snap      <= 16'h0000;
      held_mask <= 8'h00;
      state     <= IDLE;
    end else begin
      kc_q  <= keycode;
      state <= state_nx;
      if (state == IDLE && state_nx == REL0) snap <= kc_norm;
      if (state == COMMIT) begin
        prev      <= snap;
        held_mask <= key_mask(snap);
      end
    end
  end

  // One candidate event per scan state; releases first, slot0 before slot1.
  always_comb begin
    state_nx   = state;
    scan_push  = 1'b0;
    scan_press = 1'b0;
    scan_code  = 8'h00;
    case (state)
      IDLE: if (!kc_err && kc_norm != prev) state_nx = REL0;
      REL0: begin
        scan_code = prev[7:0];
        scan_push = (prev[7:0] != 8'h00) && !in_set(prev[7:0], snap);
        state_nx  = REL1;
      end
      REL1: begin
        scan_code = prev[15:8];
        scan_push = (prev[15:8] != 8'h00) && !in_set(prev[15:8], snap);
        state_nx  = PRS0;
      end
      PRS0: begin
        scan_code  = snap[7:0];
        scan_press = 1'b1;
        scan_push  = (snap[7:0] != 8'h00) && !in_set(snap[7:0], prev);
        state_nx   = PRS1;
      end
      PRS1: begin
        scan_code  = snap[15:8];
        scan_press = 1'b1;
        scan_push  = (snap[15:8] != 8'h00) && !in_set(snap[15:8], prev);
        state_nx   = COMMIT;
      end
      COMMIT: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign full  = (fifo_count == CW'(FIFO_DEPTH));
  assign empty = (fifo_count == '0);
  assign pop   = !empty && evt_ready;

`ifdef KEYCODE_AUTOREPEAT_EN
  logic [31:0] rep_cnt;
  logic        rep_first, rep_due, rep_push;

  assign rep_due  = rep_cnt == (rep_first ? 32'(REPEAT_DELAY - 1) : 32'(REPEAT_PERIOD - 1));
  // Repeats never contend with scan pushes (IDLE only) and never overflow.
  assign rep_push = (state == IDLE) && (prev[7:0] != 8'h00) && rep_due && !full;

  always_ff @(posedge clk) begin
    if (reset || state == COMMIT || prev[7:0] == 8'h00) begin
      rep_cnt   <= 32'd0;
      rep_first <= 1'b1;
    end else if (rep_due) begin
      // A due repeat outside IDLE waits; the scan's COMMIT restarts the count.
      if (state == IDLE) begin
        rep_cnt   <= 32'd0;
        rep_first <= 1'b0;
      end
    end else begin
      rep_cnt <= rep_cnt + 32'd1;
    end
  end

  assign push       = scan_push || rep_push;
  assign push_entry = scan_push ? {1'b0, scan_press, scan_code}
                                : {1'b1, 1'b1, prev[7:0]};
  assign evt_repeat = !empty && head[9];
`else
  assign push       = scan_push;
  assign push_entry = {scan_press, scan_code};
  assign evt_repeat = 1'b0;
`endif

  // A pop frees the slot, so a push into a full FIFO with a pop still lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && full && !pop;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = !empty;
  assign evt_code  = empty ? 8'h00 : head[7:0];
  assign evt_press = !empty && head[8];

endmodule
